// File: rtl/sdram_pkg.sv
// Shared types, interface constants and burst-sizing helper for the f2h_sdram writer.
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2,
        DONE      = 2'd3
    } sdram_writer_state_t;

    localparam int F2HSDRAM_DW    = 256;
    localparam int F2HSDRAM_ADDRW = 27;

    // Beats for the next burst: the frame tail may be shorter than a full burst.
    function automatic logic [31:0] min_burst(input logic [31:0] remaining,
                                              input logic [31:0] burst_len);
        return (remaining < burst_len) ? remaining : burst_len;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy output; also exposes the entry behind the head.
module sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [WIDTH-1:0]             next_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [PW-1:0]    rd_next_s;

    assign rd_next_s = rd_ptr_q + PW'(1);

    // Pointer and occupancy bookkeeping; clear discards contents of a previous frame.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_next_s;
            end
            level_q <= level_q + LW'(push_i) - LW'(pop_i);
        end
    end

    // Storage array, no reset needed: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_next_s];
    assign level_o = level_q;

endmodule

// File: rtl/sdram_writer.sv
// Avalon-MM burst write master draining a 256-bit stream into f2h_sdram, one frame per start.
// Optional statistics counters are built when SDRAM_WRITER_STATS_EN is defined.
module sdram_writer
    import sdram_pkg::*;
#(
    parameter int SDRAM_DATA_WIDTH = F2HSDRAM_DW,
    parameter int SDRAM_ADDR_WIDTH = F2HSDRAM_ADDRW,
    parameter int BURST_LEN        = 8,
    parameter int FRAME_WORDS      = 259200,
    parameter int FIFO_DEPTH       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [SDRAM_ADDR_WIDTH-1:0]   base_addr_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic [SDRAM_DATA_WIDTH-1:0]   st_data_i,
    input  logic                          st_valid_i,
    output logic                          st_ready_o,
    output logic [SDRAM_ADDR_WIDTH-1:0]   sdram_address_o,
    output logic [7:0]                    sdram_burstcount_o,
    output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
    output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
    output logic                          sdram_write_o,
    input  logic                          sdram_waitrequest_i,
    output logic [31:0]                   stall_cycles_o,
    output logic [31:0]                   burst_total_o
);
    localparam int AW    = SDRAM_ADDR_WIDTH;
    localparam int DW    = SDRAM_DATA_WIDTH;
    localparam int REM_W = $clog2(FRAME_WORDS + 1);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    sdram_writer_state_t state_q;
    logic [AW-1:0]       addr_q;
    logic [AW-1:0]       address_q;
    logic [REM_W-1:0]    remaining_q;
    logic [REM_W-1:0]    pushed_q;
    logic [7:0]          beats_q;
    logic [7:0]          burstcount_q;
    logic [DW-1:0]       writedata_q;
    logic [DW/8-1:0]     byteenable_q;
    logic                write_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;

    logic                start_s;
    logic                push_s;
    logic                beat_s;
    logic                last_beat_s;
    logic                ready_d;
    logic [7:0]          blen_d;
    logic [LVL_W-1:0]    level_s;
    logic [LVL_W-1:0]    level_d;
    logic [REM_W-1:0]    pushed_d;
    logic [DW-1:0]       head_s;
    logic [DW-1:0]       next_s;

    // Handshakes and look-ahead values; ready is registered so it is computed from next-cycle occupancy.
    always_comb begin
        start_s     = (state_q == IDLE) && start_i;
        push_s      = st_valid_i && ready_q;
        beat_s      = write_q && !sdram_waitrequest_i;
        last_beat_s = beat_s && (beats_q == 8'd1);
        blen_d      = 8'(min_burst(32'(remaining_q), 32'(BURST_LEN)));
        level_d     = level_s + LVL_W'(push_s) - LVL_W'(beat_s);
        pushed_d    = pushed_q + REM_W'(push_s);
        ready_d     = (level_d != LVL_W'(FIFO_DEPTH)) && (pushed_d != REM_W'(FRAME_WORDS));
    end

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_s),
        .push_i  (push_s),
        .data_i  (st_data_i),
        .pop_i   (beat_s),
        .head_o  (head_s),
        .next_o  (next_s),
        .level_o (level_s)
    );

    // Frame sequencer with all bus and handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            address_q    <= '0;
            remaining_q  <= '0;
            pushed_q     <= '0;
            beats_q      <= 8'd0;
            burstcount_q <= 8'd0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            write_q      <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            pushed_q <= pushed_d;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_s) begin
                        addr_q      <= base_addr_i;
                        remaining_q <= REM_W'(FRAME_WORDS);
                        pushed_q    <= '0;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b1;
                        state_q     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    ready_q <= ready_d;
                    if (32'(level_s) >= 32'(blen_d)) begin
                        write_q      <= 1'b1;
                        address_q    <= addr_q;
                        burstcount_q <= blen_d;
                        beats_q      <= blen_d;
                        writedata_q  <= head_s;
                        byteenable_q <= '1;
                        state_q      <= BURST;
                    end
                end
                BURST: begin
                    ready_q <= ready_d;
                    if (last_beat_s) begin
                        write_q      <= 1'b0;
                        writedata_q  <= '0;
                        byteenable_q <= '0;
                        addr_q       <= addr_q + AW'(burstcount_q);
                        remaining_q  <= remaining_q - REM_W'(burstcount_q);
                        if (remaining_q == REM_W'(burstcount_q)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            state_q <= WAIT_DATA;
                        end
                    end else if (beat_s) begin
                        // Head is being popped, so the word behind it becomes the next beat.
                        beats_q     <= beats_q - 8'd1;
                        writedata_q <= next_s;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    write_q <= 1'b0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SDRAM_WRITER_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] bursts_q;

    // Saturating stall and completed-burst counters, cleared by each accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_s) begin
            stall_q  <= 32'd0;
            bursts_q <= 32'd0;
        end else begin
            if (write_q && sdram_waitrequest_i && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (last_beat_s && (bursts_q != 32'hFFFF_FFFF)) begin
                bursts_q <= bursts_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_q;
    assign burst_total_o  = bursts_q;
`else
    assign stall_cycles_o = 32'd0;
    assign burst_total_o  = 32'd0;
`endif

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign st_ready_o         = ready_q;
    assign sdram_address_o    = address_q;
    assign sdram_burstcount_o = burstcount_q;
    assign sdram_writedata_o  = writedata_q;
    assign sdram_byteenable_o = byteenable_q;
    assign sdram_write_o      = write_q;

endmodule

// File: tb/tb_sdram_writer.sv
// Randomized bench for sdram_writer: a frame/burst-level model predicts every output each cycle.
module tb_sdram_writer;
    localparam int DW    = 256;
    localparam int AW    = 27;
    localparam int BEW   = DW / 8;
    localparam int BL    = 8;
    localparam int FW    = 20;
    localparam int DEPTH = 32;
    localparam bit STATS_ON =
`ifdef SDRAM_WRITER_STATS_EN
        1'b1;
`else
        1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [AW-1:0]   base_addr_i;
    logic            busy_o;
    logic            done_o;
    logic [DW-1:0]   st_data_i;
    logic            st_valid_i;
    logic            st_ready_o;
    logic [AW-1:0]   sdram_address_o;
    logic [7:0]      sdram_burstcount_o;
    logic [DW-1:0]   sdram_writedata_o;
    logic [BEW-1:0]  sdram_byteenable_o;
    logic            sdram_write_o;
    logic            sdram_waitrequest_i;
    logic [31:0]     stall_cycles_o;
    logic [31:0]     burst_total_o;

    always #5 clk = ~clk;

    sdram_writer #(
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .base_addr_i         (base_addr_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .st_data_i           (st_data_i),
        .st_valid_i          (st_valid_i),
        .st_ready_o          (st_ready_o),
        .sdram_address_o     (sdram_address_o),
        .sdram_burstcount_o  (sdram_burstcount_o),
        .sdram_writedata_o   (sdram_writedata_o),
        .sdram_byteenable_o  (sdram_byteenable_o),
        .sdram_write_o       (sdram_write_o),
        .sdram_waitrequest_i (sdram_waitrequest_i),
        .stall_cycles_o      (stall_cycles_o),
        .burst_total_o       (burst_total_o)
    );

    int errors = 0;
    int checks = 0;

    // Model state: words sent but not yet written, and the burst plan of the frame.
    logic [DW-1:0] data_q[$];
    logic [AW-1:0] bq_addr[$];
    int            bq_len[$];
    logic [AW-1:0] cur_addr;
    int            cur_len, beats_left, beats_in_cur;
    bit            arm, busy_exp, done_exp, hs, mon_en;
    int            pushes, beats, stall_m, bursts_m, done_cnt, nobs;
    logic [AW-1:0] obs_addr [8];
    int            obs_len [8];
    int            vmode, wmode, cyc, stall_left;
    bit            stall_arm;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] gen_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // Per-cycle comparison of every output against the model, then model update.
    task automatic monitor();
        int lvl;
        bit waiting, exp_wr, last_frame;
        lvl     = pushes - beats;
        waiting = busy_exp && (beats_left == 0) && !arm;
        if (arm) begin
            arm          = 1'b0;
            cur_addr     = bq_addr.pop_front();
            cur_len      = bq_len.pop_front();
            beats_left   = cur_len;
            beats_in_cur = 0;
            if (nobs < 8) begin
                obs_addr[nobs] = sdram_address_o;
                obs_len[nobs]  = int'(sdram_burstcount_o);
            end
            nobs++;
        end
        exp_wr = (beats_left > 0);
        chk("write", sdram_write_o, exp_wr);
        chk("busy", busy_o, busy_exp);
        chk("done", done_o, done_exp);
        if (done_o) done_cnt++;
        chk("ready", st_ready_o, busy_exp && (lvl < DEPTH) && (pushes < FW));
        chk("byteenable", sdram_byteenable_o, {BEW{exp_wr}});
        chk("stall_cycles", stall_cycles_o, STATS_ON ? stall_m : 0);
        chk("burst_total", burst_total_o, STATS_ON ? bursts_m : 0);
        done_exp   = 1'b0;
        last_frame = 1'b0;
        if (exp_wr) begin
            chk("address", sdram_address_o, cur_addr);
            chk("burstcount", sdram_burstcount_o, cur_len);
            if (data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL writedata: got %0h expected nothing (no word outstanding)", sdram_writedata_o);
            end else begin
                chk("writedata", sdram_writedata_o, data_q[0]);
            end
            if (!sdram_waitrequest_i) begin
                if (data_q.size() > 0) void'(data_q.pop_front());
                beats++;
                beats_left--;
                beats_in_cur++;
                if (beats_left == 0) begin
                    bursts_m++;
                    if (bq_len.size() == 0) last_frame = 1'b1;
                end
            end else begin
                stall_m++;
            end
        end
        if (last_frame) begin
            busy_exp = 1'b0;
            done_exp = 1'b1;
        end
        if (waiting && (bq_len.size() > 0) && (lvl >= bq_len[0])) arm = 1'b1;
        hs = st_valid_i && st_ready_o;
        if (hs) begin
            data_q.push_back(st_data_i);
            pushes++;
        end
    endtask

    task automatic drive();
        cyc++;
        if (hs) st_data_i = gen_word();
        if (!(st_valid_i && !hs)) begin
            case (vmode)
                0:       st_valid_i = 1'b1;
                1:       st_valid_i = (cyc % 3 == 0);
                default: st_valid_i = 1'($urandom_range(0, 1));
            endcase
        end
        case (wmode)
            1: sdram_waitrequest_i = ($urandom_range(0, 3) == 0);
            2: begin
                if (stall_left > 0) begin
                    sdram_waitrequest_i = 1'b1;
                    stall_left--;
                end else if (stall_arm && beats_in_cur == 3 && beats_left > 0) begin
                    stall_arm = 1'b0;
                    sdram_waitrequest_i = 1'b1;
                    stall_left = 2;
                end else begin
                    sdram_waitrequest_i = 1'b0;
                end
            end
            default: sdram_waitrequest_i = 1'b0;
        endcase
        hs = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_model();
        data_q.delete();
        bq_addr.delete();
        bq_len.delete();
        busy_exp = 1'b0; done_exp = 1'b0; arm = 1'b0;
        beats_left = 0; beats_in_cur = 0; pushes = 0; beats = 0;
        stall_m = 0; bursts_m = 0; done_cnt = 0; nobs = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mon_en = 1'b0;
        hs = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_write", sdram_write_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ready", st_ready_o, 0);
        chk("rst_address", sdram_address_o, 0);
        chk("rst_burstcount", sdram_burstcount_o, 0);
        chk("rst_writedata", sdram_writedata_o, 0);
        chk("rst_byteenable", sdram_byteenable_o, 0);
        chk("rst_stall_cycles", stall_cycles_o, 0);
        chk("rst_burst_total", burst_total_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        mon_en = 1'b1;
    endtask

    // Pulse start and build the expected burst plan from the frame size and burst limit.
    task automatic begin_frame(logic [AW-1:0] base);
        logic [AW-1:0] a;
        int rem, l;
        base_addr_i = base;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        clear_model();
        a = base;
        rem = FW;
        while (rem > 0) begin
            l = (rem < BL) ? rem : BL;
            bq_addr.push_back(a);
            bq_len.push_back(l);
            a = a + AW'(l);
            rem -= l;
        end
        busy_exp = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL frame_timeout: got no done_o after %0d cycles expected one", n);
        end
        repeat (3) tick();
        chk("done_pulses", done_cnt, 1);
        chk("beats_total", beats, FW);
    endtask

    task automatic run_frame(logic [AW-1:0] base, int v, int w);
        vmode = v;
        wmode = w;
        begin_frame(base);
        wait_done();
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0;
        st_valid_i = 1'b0; st_data_i = gen_word(); sdram_waitrequest_i = 1'b0;
        vmode = 0; wmode = 0; cyc = 0; stall_left = 0; stall_arm = 1'b0;
        clear_model();
        do_reset();
        repeat (2) tick();

        // Steady source, no stalls: 8 + 8 + 4 beats from 0x100.
        run_frame(27'h100, 0, 0);
        chk("t1_nbursts", nobs, 3);
        chk("t1_addr0", obs_addr[0], 27'h100);
        chk("t1_len0", obs_len[0], 8);
        chk("t1_addr1", obs_addr[1], 27'h108);
        chk("t1_len1", obs_len[1], 8);
        chk("t1_addr2", obs_addr[2], 27'h110);
        chk("t1_len2", obs_len[2], 4);

        // Three-cycle slave stall after the third beat of the first burst.
        stall_arm = 1'b1;
        stall_left = 0;
        run_frame(27'h100, 0, 2);
        chk("t2_stall_model", stall_m, 3);
        chk("t2_stall_cycles", stall_cycles_o, STATS_ON ? 3 : 0);
        chk("t2_burst_total", burst_total_o, STATS_ON ? 3 : 0);

        // Sparse source: one word every third cycle.
        run_frame(AW'($urandom()), 1, 0);
        chk("t3_nbursts", nobs, 3);

        // Address wraps at the top of the word space.
        run_frame(27'h7FF_FFFC, 0, 0);
        chk("t4_addr0", obs_addr[0], 27'h7FF_FFFC);
        chk("t4_addr1", obs_addr[1], 27'h000_0004);
        chk("t4_addr2", obs_addr[2], 27'h000_000C);

        // A second start while busy is ignored.
        vmode = 2;
        wmode = 1;
        begin_frame(27'h2000);
        repeat (10) tick();
        base_addr_i = 27'h5555;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done();
        chk("t5_addr0", obs_addr[0], 27'h2000);
        chk("t5_addr2", obs_addr[2], 27'h2010);

        // Reset during the third beat, then a clean frame.
        vmode = 0;
        wmode = 0;
        begin_frame(27'h300);
        begin
            int n = 0;
            while (!(beats_in_cur == 3 && beats_left > 0) && n < 200) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 200) begin
                errors++;
                $display("FAIL t6_reach_beat3: got no third beat expected one within 200 cycles");
            end
        end
        do_reset();
        repeat (2) tick();
        run_frame(27'h400, 2, 1);
        chk("t6_addr0", obs_addr[0], 27'h400);

        // Random frames.
        for (int k = 0; k < 3; k++) begin
            run_frame(AW'($urandom()), $urandom_range(0, 2), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
